// File: rtl/wb_port_arbiter.sv
// MEM/WB register plus register-file write-port arbiter with a multi-cycle result FIFO.
// Define LOAD_EXT_EN to enable LB/LBU/LH/LHU load formatting; otherwise loads write the raw word.
module wb_port_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    mem_valid,
    input  logic                    mem_reg_write,
    input  logic                    mem_mem_to_reg,
    input  logic [AW-1:0]           mem_dest,
    input  logic [DW-1:0]           mem_alu_out,
    input  logic [DW-1:0]           mem_read_data,
    input  logic [2:0]              mem_load_type,
    input  logic                    mc_valid,
    input  logic [AW-1:0]           mc_dest,
    input  logic [DW-1:0]           mc_data,
    output logic                    mc_ready,
    input  logic [AW-1:0]           q_a1,
    input  logic [AW-1:0]           q_a2,
    output logic                    pend_hit,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    WE3,
    output logic [AW-1:0]           A3,
    output logic [DW-1:0]           WD3
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          r_wb_valid;
    logic          r_wb_reg_write;
    logic          r_wb_m2r;
    logic [AW-1:0] r_wb_dest;
    logic [DW-1:0] r_wb_alu;
    logic [DW-1:0] r_wb_rdata;
`ifdef LOAD_EXT_EN
    logic [2:0]    r_wb_ltype;
`endif

    logic [AW-1:0] r_fifo_dest [DEPTH];
    logic [DW-1:0] r_fifo_data [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_pipe_we;
    logic          w_push;
    logic          w_pop;
    logic          w_mc_acc;
    logic [DW-1:0] w_load;
    logic [DW-1:0] w_wb_data;
    logic          w_buf_hit;
    logic [PW-1:0] w_off;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_m2r       <= 1'b0;
            r_wb_dest      <= '0;
            r_wb_alu       <= '0;
            r_wb_rdata     <= '0;
`ifdef LOAD_EXT_EN
            r_wb_ltype     <= '0;
`endif
        end else if (flush) begin
            r_wb_valid     <= 1'b0;
        end else if (!stall) begin
            r_wb_valid     <= mem_valid;
            r_wb_reg_write <= mem_reg_write;
            r_wb_m2r       <= mem_mem_to_reg;
            r_wb_dest      <= mem_dest;
            r_wb_alu       <= mem_alu_out;
            r_wb_rdata     <= mem_read_data;
`ifdef LOAD_EXT_EN
            r_wb_ltype     <= mem_load_type;
`endif
        end
    end

`ifdef LOAD_EXT_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lane select on the stored effective address
    always_comb begin
        w_byte = 8'(r_wb_rdata >> {r_wb_alu[1:0], 3'b000});
        w_half = 16'(r_wb_rdata >> {r_wb_alu[1], 4'b0000});
        case (r_wb_ltype)
            3'd1:    w_load = {{(DW-8){w_byte[7]}}, w_byte};
            3'd2:    w_load = {{(DW-8){1'b0}}, w_byte};
            3'd3:    w_load = {{(DW-16){w_half[15]}}, w_half};
            3'd4:    w_load = {{(DW-16){1'b0}}, w_half};
            default: w_load = r_wb_rdata;
        endcase
    end
`else
    logic w_unused;
    assign w_unused = ^mem_load_type;
    assign w_load   = r_wb_rdata;
`endif

    assign w_wb_data = r_wb_m2r ? w_load : r_wb_alu;
    assign w_pipe_we = r_wb_valid & r_wb_reg_write & (r_wb_dest != '0);

    assign mc_ready   = (r_count < CW'(DEPTH));
    assign fifo_count = r_count;
    assign w_mc_acc   = mc_valid & mc_ready;
    assign w_push     = w_mc_acc & (mc_dest != '0);
    assign w_pop      = ~w_pipe_we & (r_count != '0);

    always_comb begin
        WE3 = 1'b0;
        A3  = '0;
        WD3 = '0;
        if (w_pipe_we) begin
            WE3 = 1'b1;
            A3  = r_wb_dest;
            WD3 = w_wb_data;
        end else if (r_count != '0) begin
            WE3 = 1'b1;
            A3  = r_fifo_dest[r_rd_ptr];
            WD3 = r_fifo_data[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_dest[r_wr_ptr] <= mc_dest;
            r_fifo_data[r_wr_ptr] <= mc_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry i is live when its distance from the read pointer is below count
    always_comb begin
        w_buf_hit = 1'b0;
        w_off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_rd_ptr;
            if (({1'b0, w_off} < r_count) && (r_fifo_dest[i] != '0) &&
                ((r_fifo_dest[i] == q_a1) || (r_fifo_dest[i] == q_a2)))
                w_buf_hit = 1'b1;
        end
    end

    assign pend_hit = w_buf_hit |
                      (w_mc_acc & (mc_dest != '0) &
                       ((mc_dest == q_a1) | (mc_dest == q_a2)));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts
// every cycle's write-port, FIFO and hazard outputs; a negedge monitor compares.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic        mem_valid, mem_reg_write, mem_mem_to_reg;
    logic [4:0]  mem_dest;
    logic [31:0] mem_alu_out, mem_read_data;
    logic [2:0]  mem_load_type;
    logic        mc_valid;
    logic [4:0]  mc_dest;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic [4:0]  q_a1, q_a2;
    logic        pend_hit;
    logic [1:0]  fifo_count;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;

    wb_port_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_dest(mem_dest),
        .mem_alu_out(mem_alu_out), .mem_read_data(mem_read_data),
        .mem_load_type(mem_load_type),
        .mc_valid(mc_valid), .mc_dest(mc_dest), .mc_data(mc_data),
        .mc_ready(mc_ready), .q_a1(q_a1), .q_a2(q_a2),
        .pend_hit(pend_hit), .fifo_count(fifo_count),
        .WE3(WE3), .A3(A3), .WD3(WD3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd3;
        logic        ready;
        logic [1:0]  count;
        logic        pend;
    } exp_t;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } ent_t;

    exp_t exp_q[$];
    ent_t m_fifo[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        m_v, m_rw, m_m2r;
    logic [4:0]  m_dest;
    logic [31:0] m_alu, m_rd;
    logic [2:0]  m_lt;

    function automatic logic [31:0] fmt(input logic m2r, input logic [31:0] alu,
                                        input logic [31:0] rd, input logic [2:0] lt);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * alu[1:0])) & 32'hFF;
        h = (rd >> (16 * alu[1])) & 32'hFFFF;
        if (!m2r) return alu;
`ifdef LOAD_EXT_EN
        case (lt)
            3'd1: return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd2: return b;
            3'd3: return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4: return h;
            default: return rd;
        endcase
`else
        if (lt == 3'd7 && b == 32'h1FF && h == 32'h1FFFF) return rd;
        return rd;
`endif
    endfunction

    exp_t mon_e, mon_a;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = '{we: WE3, a3: A3, wd3: WD3, ready: mc_ready,
                      count: fifo_count, pend: pend_hit};
            n_checks++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL port_cycle t=%0t got we=%0b a3=%0d wd3=%08h rdy=%0b cnt=%0d pend=%0b exp we=%0b a3=%0d wd3=%08h rdy=%0b cnt=%0d pend=%0b",
                         $time, mon_a.we, mon_a.a3, mon_a.wd3, mon_a.ready, mon_a.count, mon_a.pend,
                         mon_e.we, mon_e.a3, mon_e.wd3, mon_e.ready, mon_e.count, mon_e.pend);
            end
        end
    end

    task automatic idle_inputs();
        stall = 0; flush = 0;
        mem_valid = 0; mem_reg_write = 0; mem_mem_to_reg = 0;
        mem_dest = 0; mem_alu_out = 0; mem_read_data = 0; mem_load_type = 0;
        mc_valid = 0; mc_dest = 0; mc_data = 0;
        q_a1 = 0; q_a2 = 0;
    endtask

    task automatic set_mem(input logic v, input logic rw, input logic m2r,
                           input logic [4:0] d, input logic [31:0] alu,
                           input logic [31:0] rd, input logic [2:0] lt);
        mem_valid = v; mem_reg_write = rw; mem_mem_to_reg = m2r;
        mem_dest = d; mem_alu_out = alu; mem_read_data = rd; mem_load_type = lt;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        m_v = 0; m_rw = 0; m_m2r = 0; m_dest = 0; m_alu = 0; m_rd = 0; m_lt = 0;
        m_fifo.delete();
        exp_q.push_back('{we: 0, a3: 0, wd3: 0, ready: 1, count: 0, pend: 0});
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic cycle();
        exp_t e;
        bit   pw, acc;
        pw = m_v && m_rw && (m_dest != 0);
        e  = '0;
        if (pw) begin
            e.we = 1; e.a3 = m_dest; e.wd3 = fmt(m_m2r, m_alu, m_rd, m_lt);
        end else if (m_fifo.size() > 0) begin
            e.we = 1; e.a3 = m_fifo[0].dest; e.wd3 = m_fifo[0].data;
        end
        e.ready = (m_fifo.size() < DEPTH);
        e.count = 2'(m_fifo.size());
        acc = mc_valid && e.ready && (mc_dest != 0);
        foreach (m_fifo[i])
            if (m_fifo[i].dest != 0 && (m_fifo[i].dest == q_a1 || m_fifo[i].dest == q_a2))
                e.pend = 1;
        if (acc && (mc_dest == q_a1 || mc_dest == q_a2)) e.pend = 1;
        exp_q.push_back(e);
        @(posedge clk);
        if (!pw && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (acc) m_fifo.push_back('{dest: mc_dest, data: mc_data});
        if (flush) m_v = 0;
        else if (!stall) begin
            m_v = mem_valid; m_rw = mem_reg_write; m_m2r = mem_mem_to_reg;
            m_dest = mem_dest; m_alu = mem_alu_out; m_rd = mem_read_data; m_lt = mem_load_type;
        end
        #1;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        do_reset();

        // Load formatting
        set_mem(1, 1, 1, 5, 32'h1003, 32'h80FF7F01, 3'd1); cycle();
        set_mem(1, 1, 1, 5, 32'h1003, 32'h80FF7F01, 3'd2); cycle();
        set_mem(1, 1, 1, 5, 32'h1002, 32'h80FF7F01, 3'd3); cycle();
        set_mem(1, 1, 1, 6, 32'h1001, 32'h80FF7F01, 3'd4); cycle();
        set_mem(1, 1, 1, 7, 32'h1001, 32'h80FF7F01, 3'd6); cycle();
        // ALU results, dest 0 suppressed
        set_mem(1, 1, 0, 0, 32'h12345678, 32'h0, 3'd0); cycle();
        set_mem(1, 1, 0, 9, 32'h12345678, 32'h0, 3'd0); cycle();
        set_mem(0, 0, 0, 0, 0, 0, 0); cycle(); cycle();

        // Arbitration: pipeline busy holds the mc entry
        set_mem(1, 1, 0, 4, 32'h44, 0, 0);
        q_a1 = 3;
        mc_valid = 1; mc_dest = 3; mc_data = 32'hAAAA0000; cycle();
        mc_valid = 0; cycle(); cycle();
        set_mem(0, 0, 0, 0, 0, 0, 0); cycle();
        set_mem(1, 1, 0, 4, 32'h45, 0, 0); cycle();
        set_mem(0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
        q_a1 = 0;

        // Fill buffer while busy, then drain with wrap
        set_mem(1, 1, 0, 4, 32'h46, 0, 0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            mc_valid = 1; mc_dest = 5'(10 + i); mc_data = 32'hC0DE0000 + i;
            q_a2 = 5'(10 + i);
            cycle();
        end
        mc_valid = 0; q_a2 = 0;
        set_mem(0, 0, 0, 0, 0, 0, 0);
        mc_valid = 1; mc_dest = 20; mc_data = 32'hBEEF0001; cycle();
        mc_valid = 1; mc_dest = 0;  mc_data = 32'hDEAD0000; cycle();
        mc_valid = 0;
        for (int i = 0; i < 4; i++) cycle();

        // Flush beats stall; stall alone re-drives
        set_mem(1, 1, 0, 12, 32'h1212, 0, 0); cycle();
        set_mem(1, 1, 0, 13, 32'h1313, 0, 0); flush = 1; stall = 1; cycle();
        flush = 0; stall = 0; cycle();
        set_mem(1, 1, 0, 14, 32'h1414, 0, 0); stall = 1; cycle(); cycle(); cycle();
        stall = 0; set_mem(0, 0, 0, 0, 0, 0, 0); cycle(); cycle();

        // Reset with two buffered entries
        set_mem(1, 1, 0, 4, 32'h47, 0, 0);
        mc_valid = 1; mc_dest = 21; mc_data = 32'h21; cycle();
        mc_dest = 22; mc_data = 32'h22; cycle();
        mc_valid = 0; set_mem(0, 0, 0, 0, 0, 0, 0); cycle();
        do_reset();
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                set_mem(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                        5'($urandom_range(0, 7)), $urandom, $urandom,
                        3'($urandom_range(0, 7)));
                stall    = ($urandom_range(0, 5) == 0);
                flush    = ($urandom_range(0, 9) == 0);
                mc_valid = ($urandom_range(0, 2) == 0);
                mc_dest  = 5'($urandom_range(0, 7));
                mc_data  = $urandom;
                q_a1     = 5'($urandom_range(0, 7));
                q_a2     = 5'($urandom_range(0, 7));
                cycle();
            end
        end

        idle_inputs();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Writer side of the 32x32 register file: owns the MEM/WB pipeline register and the single write port (WE3/A3/WD3).
- Formats load data, merges late results from the multi-cycle unit (mult/div) through a small buffer, and flags pending writes to the hazard unit.
- Sits between the MEM stage, the multi-cycle unit and the register file.

Parameters:
- DEPTH, 2, multi-cycle result buffer entries (power of two, >=2)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hold MEM/WB register contents
- flush  input  1  load a bubble into MEM/WB register (priority over stall)
- mem_valid  input  1  MEM stage holds a real instruction
- mem_reg_write  input  1  instruction writes a register
- mem_mem_to_reg  input  1  1 = select load data, 0 = select ALU result
- mem_dest  input  AW  destination register
- mem_alu_out  input  DW  ALU result / effective address
- mem_read_data  input  DW  raw data-memory word
- mem_load_type  input  3  0=LW 1=LB 2=LBU 3=LH 4=LHU
- mc_valid  input  1  multi-cycle result offered
- mc_dest  input  AW  its destination
- mc_data  input  DW  its value
- mc_ready  output  1  buffer can accept (valid&ready = push)
- q_a1, q_a2  input  AW  decode-stage source addresses for hazard query
- pend_hit  output  1  a buffered or incoming mc write targets q_a1 or q_a2 (ignores register 0)
- fifo_count  output  clog2(DEPTH)+1  buffered entries
- WE3  output  1  register-file write enable
- A3  output  AW  register-file write address
- WD3  output  DW  register-file write data

Behaviour:
- Reset (async, rst=1): MEM/WB valid=0, buffer empty; WE3=0, A3=0, WD3=0, mc_ready=1, fifo_count=0, pend_hit=0.
- MEM/WB register, each edge: flush -> valid=0; else stall -> hold; else capture all mem_* inputs. Fields other than valid are don't-care when valid=0.
- Latency: MEM inputs captured at edge N drive WE3/A3/WD3 combinationally during cycle N+1. The register file commits at edge N+2's preceding edge and bypasses same-cycle reads.
- Held register under stall re-drives the identical write. This is idempotent and legal.
- Pipeline write active when wb_valid & wb_reg_write & wb_dest!=0. Then WE3=1, A3=wb_dest, WD3=formatted data.
- Data select: mem_to_reg=0 -> ALU result.
- mem_to_reg=1 -> load word formatted on the stored address bits [1:0], little-endian (byte k = bits 8k+7:8k).
  - LB/LBU: selected byte, sign- or zero-extended.
  - LH/LHU: halfword at addr[1] (addr[0] ignored), sign- or zero-extended.
  - LW: whole word, address bits ignored.
  - Codes 5-7 behave as LW.
- Priority: pipeline write always wins the port.
- When no pipeline write is active and the buffer is non-empty: WE3=1, A3/WD3 = head entry, pop at edge.
- Otherwise WE3=0, A3=0, WD3=0.
- Buffer: circular FIFO of DEPTH {dest,data}.
  - mc_ready = (count<DEPTH).
  - Push and pop in the same edge: count unchanged, ordering preserved.
  - Pointers wrap modulo DEPTH.
  - Push with mc_dest=0 is accepted and dropped; it is not stored and count is unchanged.
- pend_hit: OR over valid buffer entries and (mc_valid & mc_ready) of dest==q_a1 or dest==q_a2, dest!=0. Combinational.
- Reset mid-operation discards buffered results; the multi-cycle unit is reset by the same rst.

Optional Feature:
- Macro LOAD_EXT_EN.
- Defined: full LB/LBU/LH/LHU formatting as above.
- Undefined: mem_load_type ignored, every load writes the raw mem_read_data word; byte/halfword formatting logic absent.

Test Plan:
- Load byte: mem_mem_to_reg=1, LB, read_data=0x80FF7F01, addr=0x1003, dest=5 -> next cycle WE3=1, A3=5, WD3=0xFFFFFF80. Repeat with LBU -> 0x00000080. Repeat with LH at addr 0x1002 -> 0xFFFF80FF.
- ALU result: mem_to_reg=0, alu_out=0x12345678, dest=0 -> WE3=0. Same with dest=9 -> WE3=1, A3=9, WD3=0x12345678.
- Arbitration: push mc {dest=3, 0xAAAA0000} while pipeline writes reg 4 every cycle -> entry held, fifo_count=1, pend_hit=1 for q_a1=3. Insert one bubble -> WE3=1, A3=3, WD3=0xAAAA0000, fifo_count=0.
- Full buffer: push DEPTH entries with pipeline busy -> mc_ready=0, further mc_valid ignored. Release pipeline -> entries drain in order, pointers wrap, mc_ready returns to 1 after the first pop.
- flush and stall both high with valid write in MEM -> bubble captured, WE3=0. Stall alone -> the same write is driven for consecutive cycles.
- Assert rst mid-drain with 2 buffered entries -> immediately WE3=0, fifo_count=0, mc_ready=1, no further writes after release.
